// File: rtl/cpu_bus_responder.sv
// Cache-side responder for the a1/d1/c1 CPU bus: decodes command/address, forwards to the cache core, drives the response.
// Optional protocol checker (sticky proto_err output) is enabled by defining BUS1_PROTO_CHECK_EN.
module cpu_bus_responder #(
  parameter int CACHE_OFFSET_SIZE = 5,
  parameter int ADDR1_SIZE        = 15,
  parameter int DATA1_SIZE        = 16,
  parameter int ADDR_SIZE         = ADDR1_SIZE + CACHE_OFFSET_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR1_SIZE-1:0] a1,
  inout  wire  [DATA1_SIZE-1:0] d1,
  inout  wire  [2:0]            c1,
  output logic                  core_req_valid,
  input  logic                  core_req_ready,
  output logic [2:0]            core_req_op,
  output logic [ADDR_SIZE-1:0]  core_req_addr,
  output logic [31:0]           core_req_wdata,
  input  logic                  core_rsp_valid,
  input  logic [31:0]           core_rsp_rdata,
  input  logic                  core_rsp_hit,
  output logic [31:0]           cache_hits,
  output logic [31:0]           cache_requests,
  output logic                  busy
`ifdef BUS1_PROTO_CHECK_EN
  ,
  output logic                  proto_err
`endif
);

  localparam logic [2:0] OP_READ8    = 3'd1;
  localparam logic [2:0] OP_READ16   = 3'd2;
  localparam logic [2:0] OP_READ32   = 3'd3;
  localparam logic [2:0] OP_WRITE32  = 3'd7;
  localparam logic [2:0] RSP_CODE    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR2,
    S_TURN,
    S_REQ,
    S_WAIT_RSP,
    S_RSP0,
    S_RSP1,
    S_RELEASE
  } state_t;

  state_t                       state_q, state_d;
  logic [2:0]                   op_q;
  logic [ADDR1_SIZE-1:0]        addr_hi_q;
  logic [CACHE_OFFSET_SIZE-1:0] addr_lo_q;
  logic [31:0]                  wdata_q;
  logic [31:0]                  rdata_q;
  logic                         drive_en;
  logic [DATA1_SIZE-1:0]        rsp_word;
  logic                         c1_known;
  logic                         cmd_valid;

  // An undriven or partly-X command bus reduces to X and is never taken as a command.
  assign c1_known  = ((^c1) !== 1'bx);
  assign cmd_valid = c1_known && (c1 != 3'd0);

  assign c1 = drive_en ? RSP_CODE : 3'bzzz;
  assign d1 = drive_en ? rsp_word : {DATA1_SIZE{1'bz}};

  assign core_req_op    = op_q;
  assign core_req_addr  = {addr_hi_q, addr_lo_q};
  assign core_req_wdata = wdata_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d        = state_q;
    drive_en       = 1'b0;
    core_req_valid = 1'b0;
    busy           = (state_q != S_IDLE);
    rsp_word       = '0;
    unique case (state_q)
      S_IDLE:     if (cmd_valid) state_d = S_ADDR2;
      S_ADDR2:    state_d = S_TURN;
      S_TURN:     state_d = S_REQ;
      S_REQ: begin
        core_req_valid = 1'b1;
        if (core_req_ready) state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: if (core_rsp_valid) state_d = S_RSP0;
      S_RSP0: begin
        drive_en = 1'b1;
        case (op_q)
          OP_READ8:  rsp_word = {8'h00, rdata_q[7:0]};
          OP_READ16: rsp_word = rdata_q[15:0];
          OP_READ32: rsp_word = rdata_q[15:0];
          default:   rsp_word = '0;
        endcase
        state_d = (op_q == OP_READ32) ? S_RSP1 : S_RELEASE;
      end
      S_RSP1: begin
        drive_en = 1'b1;
        rsp_word = rdata_q[31:16];
        state_d  = S_RELEASE;
      end
      S_RELEASE:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q           <= '0;
      addr_hi_q      <= '0;
      addr_lo_q      <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      cache_hits     <= '0;
      cache_requests <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q          <= c1;
            addr_hi_q     <= a1;
            wdata_q[15:0] <= d1;
          end
        end
        S_ADDR2: begin
          addr_lo_q <= a1[CACHE_OFFSET_SIZE-1:0];
          if (op_q == OP_WRITE32) wdata_q[31:16] <= d1;
        end
        S_REQ: begin
          if (core_req_ready) cache_requests <= cache_requests + 32'd1;
        end
        S_WAIT_RSP: begin
          // Responses arriving in any other state are dropped here by construction.
          if (core_rsp_valid) begin
            rdata_q <= core_rsp_rdata;
            if (core_rsp_hit) cache_hits <= cache_hits + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BUS1_PROTO_CHECK_EN
  logic proto_evt;
  logic proto_err_q;

  always_comb begin
    proto_evt = 1'b0;
    if ((state_q == S_TURN) && (c1 !== 3'b000) && (c1 !== 3'bzzz)) proto_evt = 1'b1;
    if ((state_q == S_ADDR2) && !c1_known)                          proto_evt = 1'b1;
    if (core_rsp_valid && (state_q != S_WAIT_RSP))                  proto_evt = 1'b1;
    if (core_req_valid && (core_req_ready !== 1'b0) && (core_req_ready !== 1'b1))
      proto_evt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)          proto_err_q <= 1'b0;
    else if (proto_evt) proto_err_q <= 1'b1;
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Randomized self-checking bench for cpu_bus_responder; plays the CPU and the cache core against a transaction-level model.
// Define BUS1_PROTO_CHECK_EN to also exercise the sticky proto_err output.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] a1;
  wire  [15:0] d1;
  wire  [2:0]  c1;
  logic        tb_drive;
  logic [2:0]  c1_drv;
  logic [15:0] d1_drv;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [2:0]  core_req_op;
  logic [19:0] core_req_addr;
  logic [31:0] core_req_wdata;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_rdata;
  logic        core_rsp_hit;
  logic [31:0] cache_hits;
  logic [31:0] cache_requests;
  logic        busy;
`ifdef BUS1_PROTO_CHECK_EN
  logic        proto_err;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_hits = 0;
  logic [31:0] exp_requests = 0;

  assign c1 = tb_drive ? c1_drv : 3'bzzz;
  assign d1 = tb_drive ? d1_drv : 16'hzzzz;

  always #5 clk = ~clk;

  cpu_bus_responder dut (
    .clk            (clk),
    .reset          (reset),
    .a1             (a1),
    .d1             (d1),
    .c1             (c1),
    .core_req_valid (core_req_valid),
    .core_req_ready (core_req_ready),
    .core_req_op    (core_req_op),
    .core_req_addr  (core_req_addr),
    .core_req_wdata (core_req_wdata),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_rdata (core_rsp_rdata),
    .core_rsp_hit   (core_rsp_hit),
    .cache_hits     (cache_hits),
    .cache_requests (cache_requests),
    .busy           (busy)
`ifdef BUS1_PROTO_CHECK_EN
    ,
    .proto_err      (proto_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic responder_drives();
    return (c1 === 3'd7);
  endfunction

  // Response words the CPU should see, straight from the command table.
  function automatic int rsp_count(input logic [2:0] op);
    return (op == 3'd3) ? 2 : 1;
  endfunction

  function automatic logic [15:0] rsp_word(input logic [2:0] op, input logic [31:0] rd, input int idx);
    case (op)
      3'd1:    return {8'h00, rd[7:0]};
      3'd2:    return rd[15:0];
      3'd3:    return (idx == 0) ? rd[15:0] : rd[31:16];
      default: return 16'h0000;
    endcase
  endfunction

  // Runs one bus transaction starting in IDLE; returns in the RELEASE cycle, or in the first WAIT_RSP cycle if abort is set.
  task automatic run_txn(input logic [2:0] op, input logic [14:0] hi, input logic [14:0] lo,
                         input logic [15:0] da, input logic [15:0] db,
                         input int rdly, input int wdly, input logic [31:0] rdata,
                         input logic hit, input logic abort, input logic turn_glitch);
    logic [19:0] exp_addr;
    exp_addr = {hi, lo[4:0]};
    tb_drive = 1'b1; c1_drv = op; a1 = hi; d1_drv = da;
    tick();
    check("addr2_busy", {31'b0, busy}, 32'd1);
    a1 = lo; d1_drv = db;
    tick();
    tb_drive = 1'b0;
    if (turn_glitch) begin
      tb_drive = 1'b1; c1_drv = 3'd3; d1_drv = 16'h0000;
    end
    check("turn_no_valid", {31'b0, core_req_valid}, 32'd0);
    tick();
    tb_drive = 1'b0;
    check("req_valid", {31'b0, core_req_valid}, 32'd1);
    check("req_op", {29'b0, core_req_op}, {29'b0, op});
    check("req_addr", {12'b0, core_req_addr}, {12'b0, exp_addr});
    if (op == 3'd7) check("req_wdata32", core_req_wdata, {db, da});
    else            check("req_wdata_lo", {16'b0, core_req_wdata[15:0]}, {16'b0, da});
    for (int i = 0; i < rdly; i++) begin
      core_req_ready = 1'b0;
      core_rsp_valid = 1'($urandom);
      core_rsp_hit   = 1'b1;
      tick();
      check("req_hold_valid", {31'b0, core_req_valid}, 32'd1);
      check("req_hold_addr", {12'b0, core_req_addr}, {12'b0, exp_addr});
    end
    core_rsp_valid = 1'b0;
    core_req_ready = 1'b1;
    tick();
    core_req_ready = 1'b0;
    exp_requests = exp_requests + 32'd1;
    check("req_dropped", {31'b0, core_req_valid}, 32'd0);
    check("requests", cache_requests, exp_requests);
    if (abort) return;
    for (int i = 0; i < wdly; i++) begin
      tick();
      check("wait_no_drive", {31'b0, responder_drives()}, 32'd0);
    end
    core_rsp_valid = 1'b1; core_rsp_rdata = rdata; core_rsp_hit = hit;
    tick();
    core_rsp_valid = 1'b0; core_rsp_rdata = $urandom; core_rsp_hit = 1'($urandom);
    if (hit) exp_hits = exp_hits + 32'd1;
    for (int w = 0; w < rsp_count(op); w++) begin
      if (w > 0) tick();
      check("rsp_c1", {29'b0, c1}, 32'd7);
      check("rsp_d1", {16'b0, d1}, {16'b0, rsp_word(op, rdata, w)});
    end
    check("hits", cache_hits, exp_hits);
    tick();
    check("release_no_drive", {31'b0, responder_drives()}, 32'd0);
    check("release_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic finish_release();
    tb_drive = 1'b0;
    tick();
    check("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    reset = 1'b1; a1 = '0; tb_drive = 1'b0; c1_drv = '0; d1_drv = '0;
    core_req_ready = 1'b0; core_rsp_valid = 1'b0; core_rsp_rdata = '0; core_rsp_hit = 1'b0;
    tick(); tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_valid", {31'b0, core_req_valid}, 32'd0);
    check("rst_op", {29'b0, core_req_op}, 32'd0);
    check("rst_addr", {12'b0, core_req_addr}, 32'd0);
    check("rst_wdata", core_req_wdata, 32'd0);
    check("rst_hits", cache_hits, 32'd0);
    check("rst_requests", cache_requests, 32'd0);
    check("rst_no_drive", {31'b0, responder_drives()}, 32'd0);
    reset = 1'b0;
    tick();

    // NOP on the bus is not a command.
    tb_drive = 1'b1; c1_drv = 3'd0; a1 = 15'h1234;
    tick();
    tb_drive = 1'b0;
    check("nop_idle", {31'b0, busy}, 32'd0);

    run_txn(3'd1, 15'h0040, 15'h0003, 16'hAAAA, 16'hBBBB, 0, 0, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
    check("read8_addr", {12'b0, core_req_addr}, 32'h0000_0803);
    finish_release();

    run_txn(3'd3, 15'h1357, 15'h7FFF, 16'h0, 16'h0, 4, 10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    finish_release();

    run_txn(3'd7, 15'h0101, 15'h0011, 16'h1234, 16'h5678, 1, 2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    check("write32_wdata", core_req_wdata, 32'h5678_1234);
    finish_release();

    // A command offered during RELEASE is ignored; one offered in the following IDLE cycle is accepted.
    run_txn(3'd2, 15'h0222, 15'h0002, 16'h0, 16'h0, 0, 1, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b0);
    tb_drive = 1'b1; c1_drv = 3'd2; a1 = 15'h7777;
    tick();
    check("b2b_ignored", {31'b0, busy}, 32'd0);
    run_txn(3'd1, 15'h0333, 15'h0004, 16'h0, 16'h0, 0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    finish_release();

`ifdef BUS1_PROTO_CHECK_EN
    check("proto_clean", {31'b0, proto_err}, 32'd0);
    run_txn(3'd2, 15'h0444, 15'h0005, 16'h0, 16'h0, 0, 0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1);
    check("proto_turn", {31'b0, proto_err}, 32'd1);
    finish_release();
    check("proto_sticky", {31'b0, proto_err}, 32'd1);
`endif

    for (int t = 0; t < 40; t++) begin
      rop = 3'($urandom_range(1, 7));
      run_txn(rop, 15'($urandom), 15'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'($urandom), 1'b0, 1'b0);
      finish_release();
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    // Reset in WAIT_RSP drops the transaction; a late response must not produce bus activity.
    run_txn(3'd3, 15'h0555, 15'h0006, 16'h0, 16'h0, 0, 0, 32'h0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hits = 0; exp_requests = 0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_no_drive", {31'b0, responder_drives()}, 32'd0);
    check("abort_hits", cache_hits, 32'd0);
    check("abort_requests", cache_requests, 32'd0);
    check("abort_valid", {31'b0, core_req_valid}, 32'd0);
`ifdef BUS1_PROTO_CHECK_EN
    check("proto_reset", {31'b0, proto_err}, 32'd0);
`endif
    core_rsp_valid = 1'b1; core_rsp_hit = 1'b1; core_rsp_rdata = 32'h1111_2222;
    tick();
    core_rsp_valid = 1'b0;
    check("late_rsp_busy", {31'b0, busy}, 32'd0);
    check("late_rsp_hits", cache_hits, 32'd0);
    tick();
    check("late_rsp_no_drive", {31'b0, responder_drives()}, 32'd0);

    run_txn(3'd2, 15'h0666, 15'h0007, 16'h0, 16'h0, 0, 0, 32'h0000_9999, 1'b1, 1'b0, 1'b0);
    finish_release();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Cache-side responder for the 3-wire-group CPU bus (a1/d1/c1) driven by the CPU initiator.
- Decodes a two-cycle command/address phase and handles bus turnaround.
- Forwards the request to the cache core over a valid/ready handshake.
- Drives the RESPONSE phase back on c1/d1, maintains hit and request counters, and is the driver of the counter values the CPU prints.

Parameters:
- CACHE_OFFSET_SIZE, 5, offset bits taken from the second a1 word.
- ADDR1_SIZE, 15, width of a1 and of the first address word (tag+set).
- DATA1_SIZE, 16, width of d1.
- ADDR_SIZE, ADDR1_SIZE+CACHE_OFFSET_SIZE, width of the core request address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a1  input  ADDR1_SIZE  CPU address bus: first word is tag+set, second word is offset.
- d1  inout  DATA1_SIZE  CPU data bus; driven only while drive_en, else high-Z.
- c1  inout  3  command/response bus; driven only while drive_en, else high-Z.
- core_req_valid  output  1  request to the cache core.
- core_req_ready  input  1  core accepts the request.
- core_req_op  output  3  latched command code.
- core_req_addr  output  ADDR_SIZE  {first word, second word[CACHE_OFFSET_SIZE-1:0]}.
- core_req_wdata  output  32  {high word, low word}, write data.
- core_rsp_valid  input  1  core result ready; one-cycle pulse.
- core_rsp_rdata  input  32  read data.
- core_rsp_hit  input  1  access was a hit; qualified by core_rsp_valid.
- cache_hits  output  32  hit counter.
- cache_requests  output  32  request counter.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Command codes:
  - 0 NOP
  - 1 READ8, 2 READ16, 3 READ32
  - 4 INVALIDATE_LINE
  - 5 WRITE8, 6 WRITE16, 7 WRITE32
  - Responder-driven RESPONSE is 7.
- Reset: state=IDLE, drive_en=0 (c1/d1 high-Z), core_req_valid=0, core_req_op/addr/wdata=0, cache_hits=0, cache_requests=0, busy=0.
- IDLE: on an edge with c1 in 1..7, latch op=c1, addr_hi=a1, wdata[15:0]=d1, then go to ADDR2. c1=0 or X/Z leaves the state in IDLE.
- ADDR2 (next edge): latch addr_lo=a1[CACHE_OFFSET_SIZE-1:0]. For WRITE32 also latch wdata[31:16]=d1. Go to TURN.
- TURN: exactly one cycle with nobody driving the bus (CPU releases). The responder never drives c1/d1 before leaving TURN. Go to REQ.
- REQ: core_req_valid=1 with stable op/addr/wdata until the edge where core_req_ready=1.
  - On that edge, cache_requests+=1 and state goes to WAIT_RSP.
  - If valid and ready are both high on the first REQ cycle, the transfer takes 1 cycle.
- WAIT_RSP: on core_rsp_valid, latch rdata, and if core_rsp_hit then cache_hits+=1. Go to RSP0.
  - core_rsp_valid outside WAIT_RSP is ignored.
- RSP0: drive_en=1, c1=7.
  - READ8: d1={8'h0, rdata[7:0]}.
  - READ16: d1=rdata[15:0].
  - READ32: d1=rdata[15:0], then go to RSP1.
  - All other ops: d1=0, then go to RELEASE.
- RSP1 (READ32 only): c1=7, d1=rdata[31:16]. Go to RELEASE.
- RELEASE: drive_en=0 for one cycle. c1 is not sampled as a command here. Go to IDLE.
  - A back-to-back command is therefore accepted no earlier than 1 cycle after release.
- Latency, command edge to first response cycle: 3 + (REQ wait cycles) + (WAIT_RSP cycles).
- Counters wrap modulo 2^32 with no saturation.
- Reset mid-transaction: immediate return to IDLE, bus released the same cycle, counters cleared, any pending core request dropped. The core must tolerate a dropped request.

Optional Feature:
- Macro: BUS1_PROTO_CHECK_EN.
- Defined:
  - Adds output proto_err (1 bit, sticky, cleared only by reset).
  - proto_err is set when any of these occur:
    - c1 is nonzero or not high-Z during TURN.
    - c1 is X/Z during ADDR2.
    - core_rsp_valid arrives while not in WAIT_RSP.
    - core_req_ready is X while core_req_valid=1.
  - Behaviour is otherwise unchanged; offending events are ignored exactly as without the macro.
- Undefined: no proto_err port and no checking logic.

Test Plan:
- READ8 hit: c1=1, a1=15'h0040 then a1=5'h03, core ready immediately, rdata=32'h0000_00A5, hit=1 -> d1=16'h00A5 with c1=7 for 1 cycle; cache_hits=1, cache_requests=1; core_req_addr=20'h00803.
- READ32 miss with core stall: 4 cycles of ready=0, then rsp after 10 cycles with rdata=32'hDEAD_BEEF, hit=0 -> c1=7 for 2 cycles, d1=16'hBEEF then 16'hDEAD; hits=0, requests=1; bus high-Z on the next cycle.
- WRITE32: d1=16'h1234 in cycle 1, d1=16'h5678 in cycle 2 -> core_req_op=7, core_req_wdata=32'h5678_1234; response c1=7 for 1 cycle; requests incremented.
- Back-to-back: READ16 followed by a command issued in the RELEASE cycle -> the second command is ignored until IDLE; a command issued one cycle later is accepted.
- Reset asserted during WAIT_RSP -> next cycle c1/d1 are high-Z, busy=0, counters=0; a late core_rsp_valid causes no response.
- BUS1_PROTO_CHECK_EN: CPU drives c1=3 during TURN -> proto_err=1 and stays 1 until reset; the transaction still completes normally.
